clk_div_monitor: RTL and testbench



---
 rtl/clk_div_monitor.sv | 132 +++++++++++++
 tb/tb_clk_div_monitor.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/clk_div_monitor.sv
// Samples a divided clock in the clk_in domain: edge strobes, period/high-time measurement, ratio lock
// and a lock-qualified reset. Define SYNC2_EN to add a two-flop synchronizer ahead of the sample pair.
module clk_div_monitor #(
  parameter int DIV      = 13,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4,
  parameter int W        = $clog2(2*DIV+1)
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         div_clk_in,
  output logic         rise_stb,
  output logic         fall_stb,
  output logic [W-1:0] period,
  output logic [W-1:0] high_time,
  output logic         period_vld,
  output logic         lock,
  output logic         err,
  output logic         rst_out
);

  localparam logic [W-1:0] CNT_MAX = W'(2*DIV);
  localparam logic [W-1:0] DIV_W   = W'(DIV);
  localparam logic [W-1:0] ONE     = W'(1);
  localparam logic [3:0]   LOCK_W  = 4'(LOCK_CNT);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t       state;
  logic         d_in, s0, s1;
  logic         rise_det, fall_det, match;
  logic [W-1:0] cnt, dev;
  logic [3:0]   match_cnt;
  logic [2:0]   rel_cnt;

`ifdef SYNC2_EN
  logic [1:0] sync;
  always_ff @(posedge clk_in) begin
    if (rst) sync <= '0;
    else     sync <= {sync[0], div_clk_in};
  end
  assign d_in = sync[1];
`else
  assign d_in = div_clk_in;
`endif

  assign rise_det = s0 & ~s1;
  assign fall_det = ~s0 & s1;

  // cnt is the candidate period on a rise; distance to DIV without wrap
  assign dev   = (cnt >= DIV_W) ? cnt - DIV_W : DIV_W - cnt;
  assign match = int'(dev) <= TOL;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      s0         <= 1'b0;
      s1         <= 1'b0;
      cnt        <= '0;
      state      <= SEARCH;
      match_cnt  <= '0;
      rel_cnt    <= '0;
      rise_stb   <= 1'b0;
      fall_stb   <= 1'b0;
      period     <= '0;
      high_time  <= '0;
      period_vld <= 1'b0;
      lock       <= 1'b0;
      err        <= 1'b0;
      rst_out    <= 1'b1;
    end else begin
      s0         <= d_in;
      s1         <= s0;
      rise_stb   <= rise_det;
      fall_stb   <= fall_det;
      period_vld <= 1'b0;
      err        <= 1'b0;
      if (cnt != CNT_MAX) cnt <= cnt + ONE;
      if (fall_det) high_time <= cnt;

      if (rise_det) begin
        cnt <= ONE;
        if (state != SEARCH) begin
          period     <= cnt;
          period_vld <= 1'b1;
        end
        case (state)
          SEARCH: begin
            // first edge only opens the measurement window
            state     <= TRACK;
            match_cnt <= '0;
          end
          TRACK: begin
            if (match) begin
              match_cnt <= match_cnt + 4'd1;
              if (match_cnt + 4'd1 == LOCK_W) begin
                state   <= LOCKED;
                lock    <= 1'b1;
                rel_cnt <= '0;
              end
            end else begin
              match_cnt <= '0;
              err       <= 1'b1;
            end
          end
          LOCKED: begin
            if (match) begin
              if (rel_cnt != 3'd7) rel_cnt <= rel_cnt + 3'd1;
              if (rel_cnt == 3'd6) rst_out <= 1'b0;
            end else begin
              state     <= TRACK;
              match_cnt <= '0;
              lock      <= 1'b0;
              rst_out   <= 1'b1;
              rel_cnt   <= '0;
              err       <= 1'b1;
            end
          end
          default: state <= SEARCH;
        endcase
      end else if (cnt == CNT_MAX && state != SEARCH) begin
        // no rise within two nominal periods: input lost
        state     <= SEARCH;
        match_cnt <= '0;
        lock      <= 1'b0;
        rst_out   <= 1'b1;
        rel_cnt   <= '0;
        err       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench for clk_div_monitor: an edge-level model predicts each output event and its cycle.
module tb_clk_div_monitor;
  localparam int DIV = 13, TOL = 0, LOCK_CNT = 4;
  localparam int W = $clog2(2*DIV+1);
`ifdef SYNC2_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic         clk_in = 1'b0, rst = 1'b1, div_clk_in = 1'b0;
  logic         rise_stb, fall_stb, period_vld, lock, err, rst_out;
  logic [W-1:0] period, high_time;

  clk_div_monitor #(.DIV(DIV), .TOL(TOL), .LOCK_CNT(LOCK_CNT)) dut (
    .clk_in(clk_in), .rst(rst), .div_clk_in(div_clk_in),
    .rise_stb(rise_stb), .fall_stb(fall_stb), .period(period), .high_time(high_time),
    .period_vld(period_vld), .lock(lock), .err(err), .rst_out(rst_out)
  );

  always #5 clk_in = ~clk_in;

  int ecount = 0;
  always @(posedge clk_in) ecount <= ecount + 1;

  typedef struct {
    int at;
    bit rst_chk, rise, fall, err, pvld, ht_chk, lock, rsto;
    int per, ht;
  } exp_t;
  exp_t q[$];

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, ecount, act, expv);
    end
  endtask

  // model: edge times of the observed waveform, in clk_in sample indices
  bit srch, locked, rsto, seen, prev;
  int mcnt, rcnt, last_rise;

  function automatic int sat(input int d);
    return (d > 2*DIV) ? 2*DIV : d;
  endfunction

  task automatic step(input bit v, input bit r);
    exp_t x;
    int n, p, dv;
    n = ecount + 1;
    div_clk_in = v;
    rst = r;
    x = '{default:0};
    x.at = n + LAT;
    if (r) begin
      while (q.size() > 0 && q[q.size()-1].at >= n) void'(q.pop_back());
      srch = 1; locked = 0; rsto = 1; seen = 0; prev = 0; mcnt = 0; rcnt = 0; last_rise = n;
      x.at = n; x.rst_chk = 1; x.rsto = 1;
      q.push_back(x);
    end else begin
      x.rise = v & ~prev;
      x.fall = ~v & prev;
      prev = v;
      if (x.rise) begin
        p = sat(n - last_rise);
        last_rise = n;
        seen = 1;
        if (srch) begin
          srch = 0; mcnt = 0;
        end else begin
          x.pvld = 1; x.per = p;
          dv = (p > DIV) ? p - DIV : DIV - p;
          if (dv <= TOL) begin
            if (locked) begin
              if (rcnt < 7) rcnt++;
              if (rcnt == 7) rsto = 0;
            end else begin
              mcnt++;
              if (mcnt == LOCK_CNT) begin locked = 1; rcnt = 0; end
            end
          end else begin
            x.err = 1; mcnt = 0; locked = 0; rsto = 1; rcnt = 0;
          end
        end
      end else if (!srch && n - last_rise == 2*DIV) begin
        x.err = 1; srch = 1; locked = 0; rsto = 1; mcnt = 0; rcnt = 0;
      end
      if (x.fall && seen) begin x.ht_chk = 1; x.ht = sat(n - last_rise); end
      x.lock = locked; x.rsto = rsto;
      if (x.rise || x.fall || x.err) q.push_back(x);
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic seg(input bit v, input int len);
    for (int i = 0; i < len; i++) step(v, 1'b0);
  endtask

  task automatic ideal(input int periods);
    for (int i = 0; i < periods; i++) begin seg(1'b1, 6); seg(1'b0, 7); end
  endtask

  // monitor: pops an expectation whenever one is due or the DUT shows an event
  bit cur_lock = 0, cur_rst = 1, prev_lk = 0, prev_ro = 1;
  int nrise = 0, lock_at = 0, rstf_at = 0;
  initial begin
    exp_t x;
    bit pres;
    forever begin
      @(negedge clk_in);
      pres = (rise_stb | fall_stb | err | period_vld) === 1'b1;
      while (q.size() > 0 && q[0].at < ecount) begin
        chk("missed_event_edge", ecount, q[0].at);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].at == ecount) begin
        x = q.pop_front();
        chk("rise_stb", rise_stb, x.rise);
        chk("fall_stb", fall_stb, x.fall);
        chk("err", err, x.err);
        chk("period_vld", period_vld, x.pvld);
        if (x.pvld) chk("period", period, x.per);
        if (x.ht_chk) chk("high_time", high_time, x.ht);
        if (x.rst_chk) begin
          chk("reset_period", period, 0);
          chk("reset_high_time", high_time, 0);
          nrise = 0; lock_at = 0; rstf_at = 0;
        end
        cur_lock = x.lock;
        cur_rst = x.rsto;
      end else begin
        chk("stray_event", pres, 0);
      end
      chk("lock", lock, cur_lock);
      chk("rst_out", rst_out, cur_rst);
      if (rise_stb === 1'b1) nrise++;
      if (lock === 1'b1 && !prev_lk && lock_at == 0) lock_at = nrise;
      if (rst_out === 1'b0 && prev_ro && rstf_at == 0) rstf_at = nrise;
      prev_lk = (lock === 1'b1);
      prev_ro = (rst_out !== 1'b0);
    end
  end

  initial begin
    int per, hi, r;
    repeat (3) step(1'b0, 1'b1);
    ideal(14);
    chk("lock_rise_count", lock_at, 5);
    chk("rst_out_fall_rise_count", rstf_at, 12);
    // one long period while locked
    seg(1'b1, 6); seg(1'b0, 9);
    ideal(8);
    // input stalls low until timeout
    seg(1'b1, 6); seg(1'b0, 40);
    ideal(14);
    // reset pulse mid-period while locked
    seg(1'b1, 6); seg(1'b0, 3);
    step(1'b0, 1'b1);
    seg(1'b0, 4);
    ideal(8);
    // input high at reset release
    seg(1'b1, 3); step(1'b1, 1'b1); seg(1'b1, 3); seg(1'b0, 7);
    ideal(6);
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 19);
      if (r < 12)      per = DIV;
      else if (r < 18) per = $urandom_range(DIV-3, DIV+3);
      else             per = $urandom_range(2*DIV+1, 2*DIV+6);
      hi = $urandom_range(2, per-2);
      if ($urandom_range(0, 39) == 0) step(1'b0, 1'b1);
      seg(1'b1, hi);
      seg(1'b0, per - hi);
    end
    seg(1'b0, LAT + 3);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
